// File: rtl/pc_unit_v2.sv
// pc_unit_v2 -- fetch-stage program counter with prioritised next-PC selection.
//
// Holds the fetch PC and picks the next one each rising edge, highest first:
// reset, exception entry (req), ERET return (eret), sequential/branch npc
// (enable). A small FSM marks one-cycle fetch bubbles after boot and after
// every redirect, and fetch_adel flags bad fetch addresses for CP0.
//
// Optional feature: define PC_REDIRECT_CNT_EN to build a saturating 32-bit
// redirect counter; otherwise redirect_cnt is tied to zero.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   enable       in   advance permission (0 = stall)
//   req          in   exception/interrupt entry request
//   eret         in   ERET executed, return to epc
//   epc          in   return address (low two bits ignored)
//   npc          in   next PC from branch/jump unit (taken as-is)
//   pc           out  current fetch address
//   pc_valid     out  1 = real fetch, 0 = bubble
//   fetch_adel   out  pc misaligned or outside [TEXT_LO, TEXT_HI]
//   redirect_cnt out  number of redirects taken
module pc_unit_v2 #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      EXC_VEC   = 32'h0000_4180,
    parameter logic [WIDTH-1:0]      TEXT_LO   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      TEXT_HI   = 32'h0000_6FFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             fetch_adel,
    output logic [31:0]      redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Power-up value so simulation sees a sane PC before the first reset.
    logic [WIDTH-1:0] pc_q = RESET_VEC;
    logic [WIDTH-1:0] pc_d;
    logic             redirect;

    // ERET targets are word-aligned; the dropped bits are intentionally unused.
    logic unused_epc_lo;
    assign unused_epc_lo = ^epc[1:0];

    assign redirect = req | eret;

    // Redirects ignore enable: a stall must not block exception entry or
    // return. Any edge without a redirect lands in RUN, so both the boot
    // bubble and the redirect bubble last exactly one cycle even when stalled.
    always_comb begin
        pc_d    = pc_q;
        state_d = RUN;
        if (req) begin
            pc_d    = EXC_VEC;
            state_d = REDIR;
        end else if (eret) begin
            pc_d    = {epc[WIDTH-1:2], 2'b00};
            state_d = REDIR;
        end else if (enable) begin
            pc_d    = npc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            state_q <= BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);

    // Bubbles are NOPs downstream, so they never raise an address error.
    assign fetch_adel = pc_valid &
                        ((pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI));

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // One count per redirect edge (req and eret together count once); sticks at max.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != 32'hFFFF_FFFF))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign redirect_cnt = cnt_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
    assign redirect_cnt    = 32'h0;
`endif

endmodule

// File: tb/tb_pc_unit_v2.sv
module tb_pc_unit_v2;
    localparam logic [31:0] RV = 32'h0000_3000;
    localparam logic [31:0] EV = 32'h0000_4180;
    localparam logic [31:0] LO = 32'h0000_3000;
    localparam logic [31:0] HI = 32'h0000_6FFF;
`ifdef PC_REDIRECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, req = 1'b0, eret = 1'b0;
    logic [31:0] epc = '0, npc = '0;
    logic [31:0] pc, redirect_cnt;
    logic        pc_valid, fetch_adel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the PC should be, whether the previous edge
    // left a real fetch, and how many redirects have been taken.
    logic [31:0] m_pc  = RV;
    bit          m_vld = 1'b0;
    logic [31:0] m_cnt = '0;

    always #5 clk = ~clk;

    pc_unit_v2 dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .eret(eret),
        .epc(epc), .npc(npc), .pc(pc), .pc_valid(pc_valid),
        .fetch_adel(fetch_adel), .redirect_cnt(redirect_cnt)
    );

    function automatic logic exp_adel();
        return m_vld && ((m_pc[1:0] != 2'b00) || (m_pc < LO) || (m_pc > HI));
    endfunction

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? m_cnt : 32'h0;
    endfunction

    // One clock edge with the currently driven inputs; the model follows the
    // priority rules directly. Outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pc = RV; m_vld = 1'b0; m_cnt = '0;
        end else if (req || eret) begin
            m_pc  = req ? EV : (epc & ~32'h3);
            m_vld = 1'b0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            if (enable) m_pc = npc;
            m_vld = 1'b1;
        end
        #1;
    endtask

    task automatic set_in(input logic r, input logic en, input logic rq, input logic er,
                          input logic [31:0] e, input logic [31:0] n);
        reset = r; enable = en; req = rq; eret = er; epc = e; npc = n;
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, '0, 32'h5000);
        step(); step();
        n_checks++; if (pc !== 32'h3000) $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); else n_pass++;
        n_checks++; if (pc_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", pc_valid); else n_pass++;
        n_checks++; if (fetch_adel !== 1'b0) $display("FAIL reset_adel got %b exp 0", fetch_adel); else n_pass++;
        n_checks++; if (redirect_cnt !== 32'h0) $display("FAIL reset_cnt got %h exp 0", redirect_cnt); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        set_in(0, 0, 0, 0, '0, '0);
        step();  // boot bubble ends even while stalled
        n_checks++; if (pc !== 32'h3000 || pc_valid !== 1'b1)
            $display("FAIL seq_boot got %h/%b exp 3000/1", pc, pc_valid); else n_pass++;
        exp = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 0, '0, pc + 32'd4);
            exp = exp + 32'd4;
            step();
            n_checks++; if (pc !== exp || pc_valid !== 1'b1 || fetch_adel !== 1'b0)
                $display("FAIL seq_%0d got %h/%b/%b exp %h/1/0", i, pc, pc_valid, fetch_adel, exp); else n_pass++;
        end
    endtask

    task automatic test_exception();
        // pc is 3010 here; stall plus exception must still redirect
        set_in(0, 0, 1, 0, '0, 32'h3014);
        step();
        n_checks++; if (pc !== EV || pc_valid !== 1'b0 || fetch_adel !== 1'b0)
            $display("FAIL exc_entry got %h/%b/%b exp %h/0/0", pc, pc_valid, fetch_adel, EV); else n_pass++;
        n_checks++; if (redirect_cnt !== (CNT_EN ? 32'd1 : 32'd0))
            $display("FAIL exc_cnt got %h exp %h", redirect_cnt, CNT_EN ? 32'd1 : 32'd0); else n_pass++;
        set_in(0, 0, 0, 0, '0, 32'h1234);
        step();
        n_checks++; if (pc !== EV || pc_valid !== 1'b1)
            $display("FAIL exc_bubble_end got %h/%b exp %h/1", pc, pc_valid, EV); else n_pass++;
    endtask

    task automatic test_req_eret();
        set_in(0, 1, 1, 1, 32'h3020, 32'h3100);
        step();
        n_checks++; if (pc !== EV || pc_valid !== 1'b0)
            $display("FAIL both_pc got %h/%b exp %h/0", pc, pc_valid, EV); else n_pass++;
        n_checks++; if (redirect_cnt !== (CNT_EN ? 32'd2 : 32'd0))
            $display("FAIL both_cnt got %h exp %h", redirect_cnt, CNT_EN ? 32'd2 : 32'd0); else n_pass++;
    endtask

    task automatic test_eret();
        set_in(0, 1, 0, 1, 32'h3023, 32'h5000);
        step();
        n_checks++; if (pc !== 32'h3020 || pc_valid !== 1'b0 || fetch_adel !== 1'b0)
            $display("FAIL eret_pc got %h/%b/%b exp 3020/0/0", pc, pc_valid, fetch_adel); else n_pass++;
        set_in(0, 1, 0, 0, '0, 32'h3024);
        step();
        n_checks++; if (pc !== 32'h3024 || pc_valid !== 1'b1 || fetch_adel !== 1'b0)
            $display("FAIL eret_resume got %h/%b/%b exp 3024/1/0", pc, pc_valid, fetch_adel); else n_pass++;
    endtask

    task automatic test_adel();
        logic [31:0] addrs [6] = '{32'h3002, 32'h7000, 32'hFFFF_FFFF, 32'h6FFC, 32'h2FFC, 32'h3000};
        logic        exps  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, 0, 0, '0, addrs[i]);
            step();
            n_checks++; if (pc !== addrs[i] || pc_valid !== 1'b1 || fetch_adel !== exps[i])
                $display("FAIL adel_%h got %h/%b/%b exp %h/1/%b", addrs[i], pc, pc_valid, fetch_adel,
                         addrs[i], exps[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_in_redir();
        set_in(0, 1, 1, 0, '0, 32'h3008);
        step();
        set_in(1, 0, 0, 1, 32'h5000, 32'h3008);
        step();
        n_checks++; if (pc !== RV || pc_valid !== 1'b0 || redirect_cnt !== 32'h0)
            $display("FAIL redir_reset got %h/%b/%h exp %h/0/0", pc, pc_valid, redirect_cnt, RV); else n_pass++;
        set_in(0, 0, 0, 0, '0, '0);
        step();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] n;
            n = ($urandom_range(0, 3) != 0) ? ($urandom_range(32'h3000, 32'h6FFF) & ~32'h3) : $urandom;
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom, n);
            step();
            n_checks++;
            if (pc !== m_pc || pc_valid !== m_vld || fetch_adel !== exp_adel() || redirect_cnt !== exp_cnt()) begin
                if (errs < 10)
                    $display("FAIL rand_%0d got %h/%b/%b/%h exp %h/%b/%b/%h", i, pc, pc_valid, fetch_adel,
                             redirect_cnt, m_pc, m_vld, exp_adel(), exp_cnt());
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_exception();
        test_req_eret();
        test_eret();
        test_adel();
        test_reset_in_redir();
        // resync the model with the directed history before random traffic
        set_in(1, 0, 0, 0, '0, '0);
        step();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
